// File: rtl/elevador_pkg.sv
// Shared types and constants for the four-floor elevator controller.
// The state encoding and floor width are referenced by every block.
package elevador_pkg;
  localparam int NUM_ANDARES = 4;
  localparam int ANDAR_W = 2;
  localparam int TEMP_W = 8;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } estado_t;

  function automatic logic [NUM_ANDARES-1:0] mascara_acima(
    input logic [ANDAR_W-1:0] a
  );
    logic [NUM_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_ANDARES; i++)
      if (i > int'(a)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [NUM_ANDARES-1:0] mascara_abaixo(
    input logic [ANDAR_W-1:0] a
  );
    logic [NUM_ANDARES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_ANDARES; i++)
      if (i < int'(a)) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/controle_elevador_temporizador.sv
// Loadable down-counter shared by travel and door timing.
// It holds at zero until the next load.
module temporizador
  import elevador_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TEMP_W-1:0] valor,
  output logic              zero
);
  logic [TEMP_W-1:0] contagem;

  assign zero = (contagem == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      contagem <= '0;
    else if (load)
      contagem <= valor;
    else if (!zero)
      contagem <= contagem - TEMP_W'(1);
  end
endmodule

// File: rtl/controle_elevador.sv
// Elevator controller: latches calls, travels floor by floor,
// holds the door open and keeps sweeping in the last direction.
module controle_elevador
  import elevador_pkg::*;
#(
  parameter int TEMPO_ANDAR = 8,
  parameter int TEMPO_PORTA = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_ANDARES-1:0] chamada,
  output logic [ANDAR_W-1:0]     andar,
  output logic                   subindo,
  output logic                   descendo,
  output logic                   porta_aberta,
  output logic [NUM_ANDARES-1:0] pendentes
);
  localparam logic [TEMP_W-1:0] RECARGA_ANDAR = TEMP_W'(TEMPO_ANDAR - 1);
  localparam logic [TEMP_W-1:0] RECARGA_PORTA = TEMP_W'(TEMPO_PORTA - 1);

  estado_t estado, estado_n;
  logic [ANDAR_W-1:0] andar_n, prox_acima, prox_abaixo;
  logic [NUM_ANDARES-1:0] req, pend_n;
  logic ultima_dir, dir_n;
  logic carga, expirou;
  logic [TEMP_W-1:0] valor_carga;
  logic acima, abaixo, aqui;

  assign req = pendentes | chamada;
  assign acima = |(req & mascara_acima(andar));
  assign abaixo = |(req & mascara_abaixo(andar));
  assign aqui = req[andar];
  assign prox_acima = andar + ANDAR_W'(1);
  assign prox_abaixo = andar - ANDAR_W'(1);

  temporizador u_temporizador (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (carga),
    .valor (valor_carga),
    .zero  (expirou)
  );

  always_comb begin
    estado_n = estado;
    andar_n = andar;
    dir_n = ultima_dir;
    carga = 1'b0;
    valor_carga = RECARGA_ANDAR;
    unique case (estado)
      PARADO: begin
        if (aqui) begin
          estado_n = PORTA;
          carga = 1'b1;
          valor_carga = RECARGA_PORTA;
        end else if (acima && (ultima_dir || !abaixo)) begin
          estado_n = SUBINDO;
          dir_n = 1'b1;
          carga = 1'b1;
        end else if (abaixo) begin
          estado_n = DESCENDO;
          dir_n = 1'b0;
          carga = 1'b1;
        end
      end
      SUBINDO: begin
        if (expirou) begin
          andar_n = prox_acima;
          carga = 1'b1;
          if (req[prox_acima]) begin
            estado_n = PORTA;
            valor_carga = RECARGA_PORTA;
          end else if (~|(req & mascara_acima(prox_acima))) begin
            estado_n = PARADO;
            carga = 1'b0;
          end
        end
      end
      DESCENDO: begin
        if (expirou) begin
          andar_n = prox_abaixo;
          carga = 1'b1;
          if (req[prox_abaixo]) begin
            estado_n = PORTA;
            valor_carga = RECARGA_PORTA;
          end else if (~|(req & mascara_abaixo(prox_abaixo))) begin
            estado_n = PARADO;
            carga = 1'b0;
          end
        end
      end
      PORTA: begin
        if (chamada[andar]) begin
          carga = 1'b1;
          valor_carga = RECARGA_PORTA;
        end else if (expirou) begin
          if (ultima_dir ? acima : abaixo) begin
            estado_n = ultima_dir ? SUBINDO : DESCENDO;
            carga = 1'b1;
          end else if (ultima_dir ? abaixo : acima) begin
            estado_n = ultima_dir ? DESCENDO : SUBINDO;
            dir_n = !ultima_dir;
            carga = 1'b1;
          end else begin
            estado_n = PARADO;
          end
        end
      end
      default: estado_n = PARADO;
    endcase
    // the floor being served never stays latched
    pend_n = req;
    if (estado == PORTA || estado_n == PORTA)
      pend_n[andar_n] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= PARADO;
      andar <= '0;
      pendentes <= '0;
      ultima_dir <= 1'b1;
      subindo <= 1'b0;
      descendo <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      estado <= estado_n;
      andar <= andar_n;
      pendentes <= pend_n;
      ultima_dir <= dir_n;
      subindo <= (estado_n == SUBINDO);
      descendo <= (estado_n == DESCENDO);
      porta_aberta <= (estado_n == PORTA);
    end
  end
endmodule

// File: tb/tb_controle_elevador.sv
// Bench for controle_elevador: a floor/phase-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_controle_elevador;
  localparam int TA = 8;
  localparam int TP = 4;
  localparam int M_IDLE = 0;
  localparam int M_UP = 1;
  localparam int M_DN = 2;
  localparam int M_DOOR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] chamada = 4'b0000;
  logic [1:0] andar;
  logic subindo, descendo, porta_aberta;
  logic [3:0] pendentes;

  int checks = 0;
  int failures = 0;

  int m_floor, m_mode, m_left;
  logic m_dir;
  logic [3:0] m_pend;

  controle_elevador #(
    .TEMPO_ANDAR (TA),
    .TEMPO_PORTA (TP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chamada      (chamada),
    .andar        (andar),
    .subindo      (subindo),
    .descendo     (descendo),
    .porta_aberta (porta_aberta),
    .pendentes    (pendentes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  function automatic bit any_above(input logic [3:0] r, input int f);
    for (int i = f + 1; i < 4; i++)
      if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input logic [3:0] r, input int f);
    for (int i = 0; i < f; i++)
      if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Model: floor number, phase, and cycles left in the phase.
  task automatic model_step();
    logic [3:0] req, np;
    int f, mode, left;
    logic dir;
    bit go, up;
    req = m_pend | chamada;
    f = m_floor;
    mode = m_mode;
    left = m_left;
    dir = m_dir;
    go = 1'b0;
    up = 1'b0;
    case (mode)
      M_IDLE: begin
        if (req[f]) begin
          mode = M_DOOR;
          left = TP;
        end else if (any_above(req, f) || any_below(req, f)) begin
          go = 1'b1;
          up = any_above(req, f) && (dir || !any_below(req, f));
        end
      end
      M_UP, M_DN: begin
        left--;
        if (left == 0) begin
          f = (mode == M_UP) ? f + 1 : f - 1;
          if (req[f]) begin
            mode = M_DOOR;
            left = TP;
          end else if (mode == M_UP ? any_above(req, f)
                                    : any_below(req, f)) begin
            left = TA;
          end else begin
            mode = M_IDLE;
          end
        end
      end
      default: begin
        if (chamada[f]) begin
          left = TP;
        end else begin
          left--;
          if (left == 0) begin
            if (dir ? any_above(req, f) : any_below(req, f)) begin
              go = 1'b1;
              up = dir;
            end else if (dir ? any_below(req, f) : any_above(req, f)) begin
              go = 1'b1;
              up = !dir;
            end else begin
              mode = M_IDLE;
            end
          end
        end
      end
    endcase
    if (go) begin
      mode = up ? M_UP : M_DN;
      dir = up;
      left = TA;
    end
    np = m_pend | chamada;
    if (m_mode == M_DOOR || mode == M_DOOR) np[f] = 1'b0;
    m_floor <= f;
    m_mode <= mode;
    m_left <= left;
    m_dir <= dir;
    m_pend <= np;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_floor <= 0;
      m_mode <= M_IDLE;
      m_left <= 0;
      m_dir <= 1'b1;
      m_pend <= 4'b0000;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("cycle_model",
        {andar, subindo, descendo, porta_aberta, pendentes},
        {2'(m_floor), m_mode == M_UP, m_mode == M_DN,
         m_mode == M_DOOR, m_pend});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    chamada = v;
    tick(1);
    chamada = 4'b0000;
  endtask

  task automatic wait_floor(input logic [1:0] f, output int n);
    n = 0;
    while (andar !== f && n < 200) begin
      tick(1);
      n++;
    end
    chk("wait_floor_bound", n < 200, 1);
  endtask

  task automatic wait_pend(input logic [3:0] v, output int n);
    n = 0;
    while (pendentes !== v && n < 300) begin
      tick(1);
      n++;
    end
    chk("wait_pend_bound", n < 300, 1);
  endtask

  task automatic wait_door(output int n);
    n = 0;
    while (porta_aberta !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("wait_door_bound", n < 200, 1);
  endtask

  task automatic door_len(output int n);
    n = 0;
    while (porta_aberta === 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [3:0] opened;
    int both;

    tick(2);
    chk("reset_outputs",
        {andar, subindo, descendo, porta_aberta, pendentes}, 0);
    rst_n = 1'b1;
    tick(1);

    // call at the current floor opens the door on the next edge
    pulse(4'b0001);
    chk("here_latency", porta_aberta, 1);
    door_len(n);
    chk("door_len_here", n, TP);
    chk("here_floor", andar, 0);

    // floor 0 to floor 2
    pulse(4'b0100);
    chk("up_start", subindo, 1);
    wait_floor(2'd1, n);
    chk("travel_0_1", n, 8);
    wait_floor(2'd2, n);
    chk("travel_1_2", n, 8);
    chk("door_at_2", porta_aberta, 1);
    door_len(n);
    chk("door_len_2", n, 4);
    chk("idle_after_2",
        {subindo, descendo, porta_aberta, pendentes}, 0);

    // both directions pending, last direction was up
    pulse(4'b1001);
    chk("pend_both", pendentes, 4'b1001);
    chk("up_first", subindo, 1);
    wait_pend(4'b0001, n);
    chk("served_3", {andar, porta_aberta}, {2'd3, 1'b1});
    wait_pend(4'b0000, n);
    chk("served_0", {andar, porta_aberta}, {2'd0, 1'b1});
    door_len(n);
    chk("door_len_0", n, 4);

    // door extension at floor 1
    pulse(4'b0010);
    wait_door(n);
    chk("door_at_1", andar, 1);
    tick(1);
    chamada = 4'b0010;
    tick(1);
    chamada = 4'b0000;
    chk("extend_not_latched", pendentes, 0);
    door_len(n);
    chk("door_extended_total", 2 + n, 6);

    // asynchronous reset mid-travel between floors 1 and 2
    pulse(4'b1000);
    tick(4);
    chk("mid_travel", {andar, subindo, pendentes},
        {2'd1, 1'b1, 4'b1000});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset",
        {andar, subindo, descendo, porta_aberta, pendentes}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
    chk("resume_idle",
        {andar, subindo, descendo, porta_aberta, pendentes}, 0);

    // all buttons held: door held at 0, then the rest served on release
    opened = 4'b0000;
    both = 0;
    chamada = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (porta_aberta) opened[andar] = 1'b1;
      if (subindo && descendo) both++;
    end
    chk("held_door_floor", {andar, porta_aberta}, {2'd0, 1'b1});
    chk("held_pend", pendentes, 4'b1110);
    chamada = 4'b0000;
    n = 0;
    while (!(subindo === 1'b0 && descendo === 1'b0 &&
             porta_aberta === 1'b0 && pendentes === 4'b0000) && n < 400) begin
      tick(1);
      n++;
      if (porta_aberta) opened[andar] = 1'b1;
      if (subindo && descendo) both++;
    end
    chk("sweep_bound", n < 400, 1);
    chk("all_doors_opened", opened, 4'b1111);
    chk("never_both_dirs", both, 0);
    chk("final_floor", andar, 3);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
